jtdd_colmix: RTL and testbench
==============================

Name: jtdd_colmix

Overview:
- Final colour stage, directly downstream of the object layer. Consumes the per-pixel object byte together with the character and scroll layer pixels.
- Resolves layer priority per pixel and looks the winner up in a CPU-writable palette RAM.
- Drives 4-bit RGB plus delayed blanking to the video output.
- Palette RAM is dual-ported internally, so CPU and video accesses never collide.

Parameters:
- BLANK_DLY, 2, pxl_cen periods from pixel inputs to RGB and blank outputs (fixed pipeline depth; legal range 2 only).
- SIMFILE_RG, "pal_rg.bin", simulation preload for the RG bank.
- SIMFILE_B, "pal_b.bin", simulation preload for the B bank.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pxl_cen  in  1  pixel clock enable
- cen_Q  in  1  CPU-side clock enable for palette access
- cpu_AB  in  10  CPU address; bit 9 selects bank (0=RG, 1=B), bits 8:0 are the colour index
- pal_cs  in  1  palette chip select
- cpu_wrn  in  1  CPU write, active low
- cpu_dout  in  8  CPU write data
- pal_dout  out  8  CPU read data
- char_pxl  in  7  {pal[2:0], col[3:0]}
- scr_pxl  in  7  {pal[2:0], col[3:0]}
- obj_pxl  in  8  {pal[3:0], col[3:0]}
- LHBL  in  1  horizontal blank, active low
- LVBL  in  1  vertical blank, active low
- LHBL_dly  out  1  LHBL delayed BLANK_DLY pxl_cen
- LVBL_dly  out  1  LVBL delayed BLANK_DLY pxl_cen
- red  out  4  colour output
- green  out  4  colour output
- blue  out  4  colour output

Behaviour:
- Reset (rst_n low, asynchronous):
  - red, green, blue, pal_dout = 0; LHBL_dly, LVBL_dly = 0.
  - All pipeline registers cleared.
  - Palette RAM contents are not cleared.
- Transparency: a layer is transparent when its col field == 0.
- Stage 1 (on pxl_cen): priority select, highest first:
  - char opaque -> pal_addr = {2'b00, char_pxl}
  - else obj opaque -> pal_addr = {1'b1, obj_pxl}
  - else -> pal_addr = {2'b01, scr_pxl}. Scroll is always the backstop, including col 0.
  - LHBL and LVBL are registered alongside.
- Stage 2 (on pxl_cen):
  - The RG and B banks are read at pal_addr (registered RAM output).
  - Output registers load red = RG[3:0], green = RG[7:4], blue = B[3:0].
  - When both delayed blanks are high, the output registers load the RAM values. If either is low, red, green and blue load 0.
  - LHBL_dly and LVBL_dly update in the same cycle.
- Latency: exactly 2 pxl_cen from an input pixel to its RGB value. Outputs hold their value between pxl_cen pulses.
- CPU port (on cen_Q):
  - When pal_cs && !cpu_wrn, cpu_dout is written to the bank/index given by cpu_AB.
  - All 8 bits are stored in both banks; B bits 7:4 are read back but never displayed.
  - pal_dout returns the addressed byte one cen_Q after the address is presented; it holds when pal_cs is low.
- Simultaneous CPU write and video read of the same entry in the same clock: video sees the old value. The new value is visible on the next pxl_cen read.
- Reset mid-frame: the pipeline restarts cleanly. The first valid RGB appears 2 pxl_cen after rst_n rises, with blank outputs delayed the same amount.
- No pxl_cen: all video-side registers hold; the CPU port keeps operating.

Optional Feature:
- Macro: JTDD_OBJ_PRIO_EN.
- With the macro defined, an object pixel whose obj_pxl[7] (pal MSB) = 1 is treated as behind-scroll:
  - Such an object wins only if the scroll col == 0.
  - Otherwise scroll wins.
  - char still beats both.
- Without the macro, obj_pxl[7] is ordinary palette data and objects always beat scroll.

Test Plan:
- Write RG[0x105] = 0xA3 and B[0x105] = 0x07 via the CPU, then drive obj_pxl = 0x05, char_pxl = 0x00, scr_pxl = 0x12 with blanks high -> after 2 pxl_cen: red = 3, green = A, blue = 7; CPU readback at 0x105 returns 0xA3 and at 0x305 returns 0x07.
- char_pxl = 0x31 with obj_pxl = 0x05 both opaque -> palette entry 0x031 is displayed; set char col to 0 -> entry 0x105 is displayed on the following pixel.
- char, obj and scroll all transparent with scr_pxl = 0x20 -> entry 0x0A0 (scroll pal 2, col 0) is displayed.
- LHBL low for 3 pxl_cen with opaque pixels -> RGB = 0 exactly for pxl_cen 2..4 after the falling edge; LHBL_dly mirrors LHBL with a 2-pxl_cen delay.
- CPU write to index 0x105 in the same clock as the video read of 0x105 -> old colour shown first, new colour on the next pixel; assert rst_n low mid-line -> all outputs 0 asynchronously and palette contents intact after release.
- With JTDD_OBJ_PRIO_EN: obj_pxl = 0x85 and scr_pxl = 0x13 -> scroll entry 0x093 is shown; with scr_pxl = 0x10 -> obj entry 0x185 is shown. Without the macro, obj entry 0x185 is shown in both cases.

Source files
------------

// File: rtl/jtdd_colmix_if.sv
// CPU palette bus for jtdd_colmix: address/strobe/data towards the palette and read-back data.
interface jtdd_colmix_if;
  logic [9:0] cpu_AB;
  logic       pal_cs;
  logic       cpu_wrn;
  logic [7:0] cpu_dout;
  logic [7:0] pal_dout;

  modport master (output cpu_AB, pal_cs, cpu_wrn, cpu_dout, input pal_dout);
  modport slave  (input cpu_AB, pal_cs, cpu_wrn, cpu_dout, output pal_dout);
endinterface

// File: rtl/jtdd_colmix.sv
// Final colour mixer: layer priority, palette lookup and blanking for the video output.
// Optional macro JTDD_OBJ_PRIO_EN: objects with pal MSB set sit behind opaque scroll pixels.
module jtdd_colmix #(
  parameter int BLANK_DLY  = 2,
  parameter     SIMFILE_RG = "pal_rg.bin",
  parameter     SIMFILE_B  = "pal_b.bin"
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pxl_cen,
  input  logic               cen_Q,
  jtdd_colmix_if.slave       cpu,
  input  logic [6:0]         char_pxl,
  input  logic [6:0]         scr_pxl,
  input  logic [7:0]         obj_pxl,
  input  logic               LHBL,
  input  logic               LVBL,
  output logic               LHBL_dly,
  output logic               LVBL_dly,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue
);

  logic [7:0] rg_mem [0:511];
  logic [7:0] b_mem  [0:511];

  logic [8:0] pal_addr_p1_d, pal_addr_p1_q;
  logic       lhbl_p1_d, lhbl_p1_q;
  logic       lvbl_p1_d, lvbl_p1_q;
  logic [3:0] red_p2_d, red_p2_q;
  logic [3:0] green_p2_d, green_p2_q;
  logic [3:0] blue_p2_d, blue_p2_q;
  logic       lhbl_p2_d, lhbl_p2_q;
  logic       lvbl_p2_d, lvbl_p2_q;
  logic [7:0] pal_dout_d, pal_dout_q;

  logic [7:0] rg_rd;
  logic [3:0] b_rd;
  logic [7:0] cpu_rd;
  logic       cpu_we;

  // Char beats everything; scroll is the backstop even when its col is zero.
  function automatic logic [8:0] prio_sel(input logic [6:0] ch, input logic [6:0] sc,
                                          input logic [7:0] ob);
    logic ch_op;
    logic ob_win;
    ch_op = |ch[3:0];
`ifdef JTDD_OBJ_PRIO_EN
    ob_win = (|ob[3:0]) && (!ob[7] || (sc[3:0] == 4'd0));
`else
    ob_win = |ob[3:0];
`endif
    if (ch_op)       prio_sel = {2'b00, ch};
    else if (ob_win) prio_sel = {1'b1, ob};
    else             prio_sel = {2'b01, sc};
  endfunction

  assign cpu_we = cen_Q && cpu.pal_cs && !cpu.cpu_wrn;
  assign rg_rd  = rg_mem[pal_addr_p1_q];
  assign b_rd   = b_mem[pal_addr_p1_q][3:0];
  assign cpu_rd = cpu.cpu_AB[9] ? b_mem[cpu.cpu_AB[8:0]] : rg_mem[cpu.cpu_AB[8:0]];

  // Palette banks: CPU writes here, video reads the pre-write contents in the same clock.
  always_ff @(posedge clk) begin
    if (cpu_we && !cpu.cpu_AB[9]) rg_mem[cpu.cpu_AB[8:0]] <= cpu.cpu_dout;
    if (cpu_we &&  cpu.cpu_AB[9]) b_mem[cpu.cpu_AB[8:0]]  <= cpu.cpu_dout;
  end

  always_comb begin
    pal_addr_p1_d = pal_addr_p1_q;
    lhbl_p1_d     = lhbl_p1_q;
    lvbl_p1_d     = lvbl_p1_q;
    red_p2_d      = red_p2_q;
    green_p2_d    = green_p2_q;
    blue_p2_d     = blue_p2_q;
    lhbl_p2_d     = lhbl_p2_q;
    lvbl_p2_d     = lvbl_p2_q;
    if (pxl_cen) begin
      // stage p1: priority resolve
      pal_addr_p1_d = prio_sel(char_pxl, scr_pxl, obj_pxl);
      lhbl_p1_d     = LHBL;
      lvbl_p1_d     = LVBL;
      // stage p2: palette read straight into the output registers
      lhbl_p2_d     = lhbl_p1_q;
      lvbl_p2_d     = lvbl_p1_q;
      if (lhbl_p1_q && lvbl_p1_q) begin
        red_p2_d   = rg_rd[3:0];
        green_p2_d = rg_rd[7:4];
        blue_p2_d  = b_rd;
      end else begin
        red_p2_d   = 4'd0;
        green_p2_d = 4'd0;
        blue_p2_d  = 4'd0;
      end
    end
  end

  always_comb begin
    pal_dout_d = pal_dout_q;
    if (cen_Q && cpu.pal_cs) pal_dout_d = cpu_rd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pal_addr_p1_q <= 9'd0;
      lhbl_p1_q     <= 1'b0;
      lvbl_p1_q     <= 1'b0;
      red_p2_q      <= 4'd0;
      green_p2_q    <= 4'd0;
      blue_p2_q     <= 4'd0;
      lhbl_p2_q     <= 1'b0;
      lvbl_p2_q     <= 1'b0;
      pal_dout_q    <= 8'd0;
    end else begin
      pal_addr_p1_q <= pal_addr_p1_d;
      lhbl_p1_q     <= lhbl_p1_d;
      lvbl_p1_q     <= lvbl_p1_d;
      red_p2_q      <= red_p2_d;
      green_p2_q    <= green_p2_d;
      blue_p2_q     <= blue_p2_d;
      lhbl_p2_q     <= lhbl_p2_d;
      lvbl_p2_q     <= lvbl_p2_d;
      pal_dout_q    <= pal_dout_d;
    end
  end

  assign red          = red_p2_q;
  assign green        = green_p2_q;
  assign blue         = blue_p2_q;
  assign LHBL_dly     = lhbl_p2_q;
  assign LVBL_dly     = lvbl_p2_q;
  assign cpu.pal_dout = pal_dout_q;

endmodule

// File: tb/tb_jtdd_colmix.sv
// Scoreboard bench for jtdd_colmix: randomized and directed pixels against a palette model.
module tb_jtdd_colmix;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pxl_cen = 1'b0;
  logic       cen_Q = 1'b0;
  logic [6:0] char_pxl = '0;
  logic [6:0] scr_pxl = '0;
  logic [7:0] obj_pxl = '0;
  logic       LHBL = 1'b0;
  logic       LVBL = 1'b0;
  logic       LHBL_dly, LVBL_dly;
  logic [3:0] red, green, blue;

  jtdd_colmix_if bus();

  jtdd_colmix dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pxl_cen  (pxl_cen),
    .cen_Q    (cen_Q),
    .cpu      (bus),
    .char_pxl (char_pxl),
    .scr_pxl  (scr_pxl),
    .obj_pxl  (obj_pxl),
    .LHBL     (LHBL),
    .LVBL     (LVBL),
    .LHBL_dly (LHBL_dly),
    .LVBL_dly (LVBL_dly),
    .red      (red),
    .green    (green),
    .blue     (blue)
  );

  always #5 clk = ~clk;

`ifdef JTDD_OBJ_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic       lh;
    logic       lv;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_rg [512];
  logic [7:0] m_b  [512];
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: choose the winning palette entry numerically, then apply blanking.
  function automatic exp_t model(input logic [6:0] ch, input logic [6:0] sc,
                                 input logic [7:0] ob, input logic lh, input logic lv);
    int   idx;
    exp_t e;
    if (int'(ch) % 16 != 0)
      idx = int'(ch);
    else if (int'(ob) % 16 != 0 && !(PRIO && int'(ob) >= 128 && int'(sc) % 16 != 0))
      idx = 256 + int'(ob);
    else
      idx = 128 + int'(sc);
    e.lh = lh;
    e.lv = lv;
    if (lh && lv) begin
      e.r = 4'(int'(m_rg[idx]) % 16);
      e.g = 4'(int'(m_rg[idx]) / 16);
      e.b = 4'(int'(m_b[idx]) % 16);
    end else begin
      e.r = 4'd0;
      e.g = 4'd0;
      e.b = 4'd0;
    end
    return e;
  endfunction

  // One pixel per call: a pxl_cen clock (optionally with a CPU write) then an idle clock
  // with scrambled inputs that the video side must ignore.
  task automatic step(input logic [6:0] ch, input logic [6:0] sc, input logic [7:0] ob,
                      input logic lh, input logic lv,
                      input logic wr, input logic [9:0] a, input logic [7:0] d);
    char_pxl = ch;
    scr_pxl  = sc;
    obj_pxl  = ob;
    LHBL     = lh;
    LVBL     = lv;
    pxl_cen  = 1'b1;
    if (wr) begin
      cen_Q        = 1'b1;
      bus.pal_cs   = 1'b1;
      bus.cpu_wrn  = 1'b0;
      bus.cpu_AB   = a;
      bus.cpu_dout = d;
      if (a[9]) m_b[a[8:0]] = d;
      else      m_rg[a[8:0]] = d;
    end
    sb.push_back(model(ch, sc, ob, lh, lv));
    @(negedge clk);
    pxl_cen     = 1'b0;
    cen_Q       = 1'b0;
    bus.pal_cs  = 1'b0;
    bus.cpu_wrn = 1'b1;
    char_pxl    = 7'($urandom);
    scr_pxl     = 7'($urandom);
    obj_pxl     = 8'($urandom);
    LHBL        = 1'($urandom);
    LVBL        = 1'($urandom);
    @(negedge clk);
  endtask

  task automatic pix(input logic [6:0] ch, input logic [6:0] sc, input logic [7:0] ob,
                     input logic lh, input logic lv);
    step(ch, sc, ob, lh, lv, 1'b0, 10'd0, 8'd0);
  endtask

  task automatic cpu_read(input logic [9:0] a, input string nm);
    logic [7:0] ex;
    ex = a[9] ? m_b[a[8:0]] : m_rg[a[8:0]];
    bus.cpu_AB  = a;
    bus.pal_cs  = 1'b1;
    bus.cpu_wrn = 1'b1;
    cen_Q       = 1'b1;
    @(negedge clk);
    bus.pal_cs  = 1'b0;
    check(nm, 16'(bus.pal_dout), 16'(ex));
    bus.cpu_AB  = 10'($urandom);
    @(negedge clk);
    cen_Q       = 1'b0;
    check({nm, "_hold"}, 16'(bus.pal_dout), 16'(ex));
  endtask

  // Monitor: one output per pxl_cen once the two-stage pipeline has filled.
  initial begin
    int   beats;
    exp_t e;
    exp_t last;
    logic cen_s, rst_s;
    beats = 0;
    last  = '0;
    forever begin
      @(posedge clk);
      cen_s = pxl_cen;
      rst_s = rst_n;
      @(negedge clk);
      if (!rst_n || !rst_s) begin
        beats = 0;
      end else if (cen_s) begin
        beats++;
        if (beats == 1) begin
          check("first_beat_zero", 16'({red, green, blue, LHBL_dly, LVBL_dly}), 16'd0);
        end else if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: output with no expected pixel at %0t", $time);
        end else begin
          e = sb.pop_front();
          check("pixel", 16'({red, green, blue, LHBL_dly, LVBL_dly}), 16'(e));
          last = e;
        end
      end else if (beats >= 2) begin
        check("hold", 16'({red, green, blue, LHBL_dly, LVBL_dly}), 16'(last));
      end
    end
  end

  initial begin
    logic [6:0] ch, sc;
    logic [7:0] ob;
    bus.cpu_AB   = '0;
    bus.pal_cs   = 1'b0;
    bus.cpu_wrn  = 1'b1;
    bus.cpu_dout = '0;
    for (int i = 0; i < 512; i++) begin
      m_rg[i] = 8'd0;
      m_b[i]  = 8'd0;
    end
    repeat (3) @(negedge clk);
    check("reset_state", 16'({red, green, blue, LHBL_dly, LVBL_dly, bus.pal_dout}), 16'd0);
    rst_n = 1'b1;

    // Fill every palette entry while blanked.
    for (int i = 0; i < 1024; i++)
      step(7'($urandom), 7'($urandom), 8'($urandom), 1'b0, 1'b0, 1'b1, 10'(i), 8'($urandom));

    // Random pixels with occasional CPU writes.
    for (int i = 0; i < 400; i++) begin
      ch = 7'($urandom);
      sc = 7'($urandom);
      ob = 8'($urandom);
      if ($urandom_range(1, 0) == 0) ch[3:0] = 4'd0;
      if ($urandom_range(1, 0) == 0) ob[3:0] = 4'd0;
      if ($urandom_range(3, 0) == 0) sc[3:0] = 4'd0;
      step(ch, sc, ob, $urandom_range(7, 0) != 0, $urandom_range(7, 0) != 0,
           $urandom_range(3, 0) == 0, 10'($urandom), 8'($urandom));
    end
    for (int i = 0; i < 8; i++) cpu_read(10'($urandom), "rand_readback");

    // Known entries and priority cases.
    step(7'h00, 7'h00, 8'h00, 1'b0, 1'b0, 1'b1, 10'h105, 8'hA3);
    step(7'h00, 7'h00, 8'h00, 1'b0, 1'b0, 1'b1, 10'h305, 8'h07);
    pix(7'h00, 7'h12, 8'h05, 1'b1, 1'b1);
    cpu_read(10'h105, "rb_rg105");
    cpu_read(10'h305, "rb_b105");
    pix(7'h31, 7'h12, 8'h05, 1'b1, 1'b1);
    pix(7'h30, 7'h12, 8'h05, 1'b1, 1'b1);
    pix(7'h00, 7'h20, 8'h00, 1'b1, 1'b1);

    // Horizontal blank for three pixels.
    pix(7'h31, 7'h12, 8'h05, 1'b1, 1'b1);
    repeat (3) pix(7'h31, 7'h12, 8'h05, 1'b0, 1'b1);
    repeat (3) pix(7'h31, 7'h12, 8'h05, 1'b1, 1'b1);
    pix(7'h31, 7'h12, 8'h05, 1'b1, 1'b0);

    // Write racing the video read of the same entry.
    pix(7'h00, 7'h12, 8'h05, 1'b1, 1'b1);
    step(7'h00, 7'h12, 8'h05, 1'b1, 1'b1, 1'b1, 10'h105, 8'h5C);
    pix(7'h00, 7'h12, 8'h05, 1'b1, 1'b1);
    cpu_read(10'h105, "rb_after_race");

    // Asynchronous reset mid-line.
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", 16'({red, green, blue, LHBL_dly, LVBL_dly, bus.pal_dout}), 16'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pix(7'h00, 7'h12, 8'h05, 1'b1, 1'b1);
    pix(7'h00, 7'h20, 8'h00, 1'b1, 1'b1);
    pix(7'h31, 7'h00, 8'h00, 1'b1, 1'b1);
    cpu_read(10'h105, "rb_post_reset_rg");
    cpu_read(10'h305, "rb_post_reset_b");

    // Objects with pal MSB set against opaque and transparent scroll.
    pix(7'h00, 7'h13, 8'h85, 1'b1, 1'b1);
    pix(7'h00, 7'h10, 8'h85, 1'b1, 1'b1);
    pix(7'h40, 7'h13, 8'h85, 1'b1, 1'b1);

    pix(7'h00, 7'h00, 8'h00, 1'b0, 1'b0);
    pix(7'h00, 7'h00, 8'h00, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
